// File: rtl/button_conditioner.sv
// Multi-channel button conditioner: per-channel synchroniser, strobe-timed debounce FSM,
// level/press/release outputs. Define BUTTON_CONDITIONER_REPEAT_EN to add auto-repeat presses.
module button_conditioner #(
  parameter int CHANNELS       = 2,
  parameter int DEBOUNCE_TICKS = 4,
  parameter int SYNC_STAGES    = 2,
  parameter bit ACTIVE_LOW     = 1'b0,
  parameter int REPEAT_DELAY   = 12,
  parameter int REPEAT_PERIOD  = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                countdown_en,
  input  logic [CHANNELS-1:0] button_in,
  input  logic [CHANNELS-1:0] channel_mask,
  output logic [CHANNELS-1:0] button_out,
  output logic [CHANNELS-1:0] press_pulse,
  output logic [CHANNELS-1:0] release_pulse,
  output logic                any_pressed
);

  localparam int CW = $clog2(DEBOUNCE_TICKS + 1);

  typedef enum logic [1:0] {IDLE, ARM_P, PRESSED, ARM_R} state_e;

  logic [SYNC_STAGES-1:0] sync_q  [CHANNELS];
  state_e                 state_q [CHANNELS];
  state_e                 state_d [CHANNELS];
  logic [CW-1:0]          cnt_q   [CHANNELS];
  logic [CW-1:0]          cnt_d   [CHANNELS];
  logic [CHANNELS-1:0]    s;
  logic [CHANNELS-1:0]    press_raw, release_raw, rep_fire;
  logic [CHANNELS-1:0]    press_d, press_q, release_d, release_q;

  // NOTE: every variable gets a default at the top of always_comb so no path can infer a latch.
  always_comb begin
    for (int i = 0; i < CHANNELS; i++) begin
      s[i]           = sync_q[i][SYNC_STAGES-1] ^ ACTIVE_LOW;
      state_d[i]     = state_q[i];
      cnt_d[i]       = cnt_q[i];
      press_raw[i]   = 1'b0;
      release_raw[i] = 1'b0;
      case (state_q[i])
        IDLE: begin
          if (s[i]) begin
            state_d[i] = ARM_P;
            cnt_d[i]   = CW'(DEBOUNCE_TICKS);
          end
        end
        ARM_P: begin
          // A reversal wins over a coincident strobe and leaves the counter untouched.
          if (!s[i]) begin
            state_d[i] = IDLE;
          end else if (countdown_en) begin
            if (cnt_q[i] == CW'(1)) begin
              state_d[i]   = PRESSED;
              press_raw[i] = 1'b1;
            end else begin
              cnt_d[i] = cnt_q[i] - 1'b1;
            end
          end
        end
        PRESSED: begin
          if (!s[i]) begin
            state_d[i] = ARM_R;
            cnt_d[i]   = CW'(DEBOUNCE_TICKS);
          end
        end
        ARM_R: begin
          if (s[i]) begin
            state_d[i] = PRESSED;
          end else if (countdown_en) begin
            if (cnt_q[i] == CW'(1)) begin
              state_d[i]     = IDLE;
              release_raw[i] = 1'b1;
            end else begin
              cnt_d[i] = cnt_q[i] - 1'b1;
            end
          end
        end
        default: state_d[i] = IDLE;
      endcase
    end
  end

`ifdef BUTTON_CONDITIONER_REPEAT_EN
  localparam int REP_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int RW      = $clog2(REP_MAX + 1);

  logic [RW-1:0] rep_q [CHANNELS];
  logic [RW-1:0] rep_d [CHANNELS];

  // Going to IDLE (which includes an accepted release) clears the counter first, so a
  // release always suppresses a coincident repeat.
  always_comb begin
    for (int i = 0; i < CHANNELS; i++) begin
      rep_d[i]    = rep_q[i];
      rep_fire[i] = 1'b0;
      if (state_d[i] == IDLE) begin
        rep_d[i] = '0;
      end else if (state_d[i] == PRESSED && state_q[i] != PRESSED) begin
        rep_d[i] = RW'(REPEAT_DELAY);
      end else if ((state_q[i] == PRESSED || state_q[i] == ARM_R) && countdown_en) begin
        if (rep_q[i] == RW'(1)) begin
          rep_fire[i] = 1'b1;
          rep_d[i]    = RW'(REPEAT_PERIOD);
        end else if (rep_q[i] > RW'(1)) begin
          rep_d[i] = rep_q[i] - 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < CHANNELS; i++) rep_q[i] <= '0;
    end else begin
      for (int i = 0; i < CHANNELS; i++) rep_q[i] <= rep_d[i];
    end
  end
`else
  logic unused_repeat_cfg;
  assign unused_repeat_cfg = ^{REPEAT_DELAY, REPEAT_PERIOD};
  assign rep_fire          = '0;
`endif

  assign press_d   = (press_raw | rep_fire) & ~channel_mask;
  assign release_d = release_raw & ~channel_mask;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < CHANNELS; i++) begin
        sync_q[i]  <= '0;
        state_q[i] <= IDLE;
        cnt_q[i]   <= '0;
      end
      press_q   <= '0;
      release_q <= '0;
    end else begin
      for (int i = 0; i < CHANNELS; i++) begin
        sync_q[i]  <= {sync_q[i][SYNC_STAGES-2:0], button_in[i]};
        state_q[i] <= state_d[i];
        cnt_q[i]   <= cnt_d[i];
      end
      press_q   <= press_d;
      release_q <= release_d;
    end
  end

  always_comb begin
    for (int i = 0; i < CHANNELS; i++) begin
      button_out[i] = (state_q[i] == PRESSED) || (state_q[i] == ARM_R);
    end
  end

  assign press_pulse   = press_q;
  assign release_pulse = release_q;
  assign any_pressed   = |button_out;

endmodule

// File: tb/tb_button_conditioner.sv
// Directed self-checking bench for button_conditioner (2 channels, 4 debounce ticks, 2 sync stages).
// The auto-repeat section is compiled only with BUTTON_CONDITIONER_REPEAT_EN defined.
module tb_button_conditioner;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       countdown_en;
  logic [1:0] button_in;
  logic [1:0] channel_mask;
  logic [1:0] button_out;
  logic [1:0] press_pulse;
  logic [1:0] release_pulse;
  logic       any_pressed;

  int n_checks = 0;
  int n_fail   = 0;

  button_conditioner #(
    .CHANNELS      (2),
    .DEBOUNCE_TICKS(4),
    .SYNC_STAGES   (2),
    .ACTIVE_LOW    (1'b0),
    .REPEAT_DELAY  (12),
    .REPEAT_PERIOD (4)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .countdown_en (countdown_en),
    .button_in    (button_in),
    .channel_mask (channel_mask),
    .button_out   (button_out),
    .press_pulse  (press_pulse),
    .release_pulse(release_pulse),
    .any_pressed  (any_pressed)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Inputs change and outputs are sampled on the falling edge.
  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  // One-clk strobe; returns on the falling edge right after the strobed rising edge.
  task automatic strobe();
    countdown_en = 1'b1;
    @(negedge clk);
    countdown_en = 1'b0;
  endtask

  task automatic do_reset(input logic [1:0] pins);
    rst_n        = 1'b0;
    button_in    = pins;
    channel_mask = 2'b00;
    countdown_en = 1'b0;
    step(3);
    rst_n = 1'b1;
    step(1);
  endtask

  initial begin
    // Reset with both pins high, then both channels press together.
    do_reset(2'b11);
    rst_n = 1'b0;
    step(2);
    check("rst_button_out", {6'd0, button_out}, 8'h00);
    check("rst_press", {6'd0, press_pulse}, 8'h00);
    check("rst_release", {6'd0, release_pulse}, 8'h00);
    check("rst_any", {7'd0, any_pressed}, 8'h00);
    rst_n = 1'b1;
    step(4);
    for (int k = 1; k <= 3; k++) begin
      strobe();
      check("rst_pre_press", {6'd0, press_pulse}, 8'h00);
      step(15);
    end
    check("rst_still_idle", {6'd0, button_out}, 8'h00);
    strobe();
    check("rst_dual_press", {6'd0, press_pulse}, 8'h03);
    check("rst_dual_level", {6'd0, button_out}, 8'h03);
    check("rst_dual_any", {7'd0, any_pressed}, 8'h01);
    step(1);
    check("rst_press_one_clk", {6'd0, press_pulse}, 8'h00);

    // Mid-operation reset clears everything with no pulse.
    rst_n = 1'b0;
    step(1);
    check("midrst_level", {6'd0, button_out}, 8'h00);
    check("midrst_pulses", {4'd0, press_pulse, release_pulse}, 8'h00);

    // Clean press on ch0, then an unmasked release.
    do_reset(2'b00);
    button_in = 2'b01;
    step(3);
    for (int k = 1; k <= 3; k++) begin
      strobe();
      check("clean_pre_press", {6'd0, press_pulse}, 8'h00);
      step(15);
    end
    strobe();
    check("clean_press", {6'd0, press_pulse}, 8'h01);
    check("clean_level", {6'd0, button_out}, 8'h01);
    step(1);
    check("clean_press_one_clk", {6'd0, press_pulse}, 8'h00);
    button_in = 2'b00;
    step(3);
    check("clean_arm_r_level", {6'd0, button_out}, 8'h01);
    for (int k = 1; k <= 3; k++) begin
      strobe();
      check("clean_pre_release", {6'd0, release_pulse}, 8'h00);
      step(15);
    end
    strobe();
    check("clean_release", {6'd0, release_pulse}, 8'h01);
    check("clean_release_level", {6'd0, button_out}, 8'h00);
    step(1);
    check("clean_release_one_clk", {6'd0, release_pulse}, 8'h00);

    // Bounce after two strobes forces a fresh four-strobe count.
    do_reset(2'b00);
    button_in = 2'b01;
    step(3);
    strobe(); step(15);
    strobe(); step(15);
    button_in = 2'b00;
    step(4);
    strobe();
    check("bounce_low_strobe", {4'd0, press_pulse, button_out}, 8'h00);
    step(15);
    button_in = 2'b01;
    step(3);
    for (int k = 1; k <= 3; k++) begin
      strobe();
      check("bounce_recount", {4'd0, press_pulse, button_out}, 8'h00);
      step(15);
    end
    strobe();
    check("bounce_press", {6'd0, press_pulse}, 8'h01);

    // Masked release on ch1: level follows, pulse is suppressed.
    do_reset(2'b10);
    step(3);
    for (int k = 1; k <= 4; k++) begin
      strobe();
      if (k < 4) step(15);
    end
    check("mask_setup_press", {6'd0, press_pulse}, 8'h02);
    channel_mask = 2'b10;
    button_in    = 2'b00;
    step(3);
    for (int k = 1; k <= 4; k++) begin
      strobe();
      check("mask_release_pulse", {6'd0, release_pulse}, 8'h00);
      step(15);
    end
    check("mask_level", {6'd0, button_out}, 8'h00);
    check("mask_any", {7'd0, any_pressed}, 8'h00);

    // Pin reversal on the same clk as the fourth strobe in ARM_P.
    do_reset(2'b00);
    button_in = 2'b01;
    step(3);
    for (int k = 1; k <= 3; k++) begin
      strobe(); step(15);
    end
    button_in = 2'b00;
    step(2);
    strobe();
    check("simul_no_press", {6'd0, press_pulse}, 8'h00);
    check("simul_idle", {6'd0, button_out}, 8'h00);
    step(20);
    check("simul_stays_idle", {4'd0, press_pulse, button_out}, 8'h00);

`ifdef BUTTON_CONDITIONER_REPEAT_EN
    // Auto-repeat after 12 strobes then every 4; a release coinciding with a repeat wins.
    do_reset(2'b01);
    step(3);
    for (int k = 1; k <= 4; k++) begin
      strobe();
      if (k < 4) step(15);
    end
    check("rep_initial_press", {6'd0, press_pulse}, 8'h01);
    step(15);
    for (int k = 1; k <= 24; k++) begin
      strobe();
      if (k == 12 || k == 16 || k == 20 || k == 24)
        check("rep_fire", {6'd0, press_pulse}, 8'h01);
      else
        check("rep_quiet", {6'd0, press_pulse}, 8'h00);
      step(15);
    end
    button_in = 2'b00;
    step(3);
    for (int k = 1; k <= 4; k++) begin
      strobe();
      check("rep_release_no_press", {6'd0, press_pulse}, 8'h00);
      check("rep_release_pulse", {6'd0, release_pulse}, (k == 4) ? 8'h01 : 8'h00);
      step(15);
    end
    for (int k = 1; k <= 8; k++) begin
      strobe();
      check("rep_after_release", {4'd0, press_pulse, release_pulse}, 8'h00);
      step(15);
    end
`endif

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
